// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: 2-bit direction counter encoding and
// its saturating step function.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    CtrSN = 2'b00,
    CtrWN = 2'b01,
    CtrWT = 2'b10,
    CtrST = 2'b11
  } ctr_e;

  function automatic ctr_e ctr_step(ctr_e c, logic taken);
    ctr_e n;
    unique case (c)
      CtrSN:   n = taken ? CtrWN : CtrSN;
      CtrWN:   n = taken ? CtrWT : CtrSN;
      CtrWT:   n = taken ? CtrST : CtrWN;
      default: n = taken ? CtrST : CtrWT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and execute-side resolution signals of the branch predictor.
interface branch_predictor_if;
  logic [31:0] fetch_pc;
  logic        fetch_is_ret;
  logic [31:0] predict_pc;
  logic        predict_taken;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;
  logic        update_cond;
  logic        ras_push;
  logic        ras_pop;

  modport master (
    output fetch_pc, fetch_is_ret, update_valid, update_pc, update_target,
           update_taken, update_cond, ras_push, ras_pop,
    input  predict_pc, predict_taken
  );

  modport slave (
    input  fetch_pc, fetch_is_ret, update_valid, update_pc, update_target,
           update_taken, update_cond, ras_push, ras_pop,
    output predict_pc, predict_taken
  );
endinterface

// File: rtl/return_address_stack.sv
// Circular return-address stack; overflow overwrites the oldest entry, pop on
// empty is ignored, push+pop replaces the top in place.
module return_address_stack #(
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic [31:0] i_push_data,
  output logic [31:0] o_top,
  output logic        o_empty
);
  localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  logic [PtrW-1:0] r_ptr;
  logic [CntW-1:0] r_cnt;
  logic [31:0]     r_mem [RAS_DEPTH];
  logic [PtrW-1:0] w_ptr_inc;
  logic            w_full;

  assign w_ptr_inc = r_ptr + PtrW'(1);
  assign w_full    = (r_cnt == CntW'(RAS_DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_top     = r_mem[r_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (i_push && !i_pop) begin
      r_ptr <= w_ptr_inc;
      if (!w_full) r_cnt <= r_cnt + CntW'(1);
    end else if (i_pop && !i_push && !o_empty) begin
      r_ptr <= r_ptr - PtrW'(1);
      r_cnt <= r_cnt - CntW'(1);
    end
  end

  // Storage is not reset; the write is still suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (!reset && i_push) begin
      if (i_pop) r_mem[r_ptr]     <= i_push_data;
      else       r_mem[w_ptr_inc] <= i_push_data;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit direction counters plus a return-address
// stack; combinational next-PC prediction from fetch_pc.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES   = 64,
  parameter int unsigned RAS_DEPTH = 8
) (
  input logic             clk,
  input logic             reset,
  branch_predictor_if.slave bp
);
  localparam int unsigned IdxW = $clog2(ENTRIES);
  localparam int unsigned TagW = 30 - IdxW;

  logic [ENTRIES-1:0] r_valid;
  logic [ENTRIES-1:0] r_uncond;
  ctr_e               r_ctr    [ENTRIES];
  logic [TagW-1:0]    r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];

  logic [IdxW-1:0] w_f_idx, w_u_idx;
  logic [TagW-1:0] w_f_tag, w_u_tag;
  logic            w_f_hit, w_u_hit;
  logic [31:0]     w_ras_top;
  logic            w_ras_empty;
  logic            w_unused_lsbs;

  assign w_f_idx = bp.fetch_pc[IdxW+1:2];
  assign w_f_tag = bp.fetch_pc[31:IdxW+2];
  assign w_u_idx = bp.update_pc[IdxW+1:2];
  assign w_u_tag = bp.update_pc[31:IdxW+2];
  assign w_f_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  assign w_unused_lsbs = ^{bp.fetch_pc[1:0], bp.update_pc[1:0]};

  return_address_stack #(
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .reset      (reset),
    .i_push     (bp.ras_push),
    .i_pop      (bp.ras_pop),
    .i_push_data(bp.update_pc + 32'd4),
    .o_top      (w_ras_top),
    .o_empty    (w_ras_empty)
  );

  always_comb begin
    bp.predict_pc    = bp.fetch_pc + 32'd4;
    bp.predict_taken = 1'b0;
    if (!reset) begin
      if (bp.fetch_is_ret && !w_ras_empty) begin
        bp.predict_pc    = w_ras_top;
        bp.predict_taken = 1'b1;
      end else if (w_f_hit && (r_uncond[w_f_idx] || r_ctr[w_f_idx][1])) begin
        bp.predict_pc    = r_target[w_f_idx];
        bp.predict_taken = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid  <= '0;
      r_uncond <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) r_ctr[i] <= CtrWN;
    end else if (bp.update_valid) begin
      if (w_u_hit) begin
        if (bp.update_cond) r_ctr[w_u_idx] <= ctr_step(r_ctr[w_u_idx], bp.update_taken);
      end else if (bp.update_taken) begin
        r_valid[w_u_idx]  <= 1'b1;
        r_uncond[w_u_idx] <= !bp.update_cond;
        r_ctr[w_u_idx]    <= bp.update_cond ? CtrWT : CtrST;
      end
    end
  end

  // On a hit the tag rewrite is a no-op, so one write path covers hit and allocate.
  always_ff @(posedge clk) begin
    if (!reset && bp.update_valid && bp.update_taken) begin
      r_tag[w_u_idx]    <= w_u_tag;
      r_target[w_u_idx] <= bp.update_target;
    end
  end

endmodule
